spi_master_controller: RTL and testbench



---
 rtl/spi_globals_pkg.sv | 35 +++
 rtl/spi_sclk_gen.sv | 62 ++++++
 rtl/spi_master_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_master_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_globals_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_globals_pkg
//  Description : Shared types for the SPI master controller: the controller
//                state encoding and the {cpol,cpha} mode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_globals_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_HOLD     = 2'd3
    } spi_state_e;

    // SPI modes as {cpol, cpha}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    function automatic logic mode_cpol(input spi_mode_e mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e mode);
        return mode[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SCLK divider. Counts CLK_DIV system clocks per half-period,
//                flags the end of each half-period and, when edges are
//                enabled, toggles SCLK and classifies the toggle as a
//                leading or trailing edge relative to the idle polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,         // counter runs while high, held at zero otherwise
    input  logic edge_en,     // allow SCLK to toggle at the end of this half-period
    input  logic load,        // force SCLK to load_cpol (start of a transfer)
    input  logic load_cpol,
    input  logic cpol,        // latched idle polarity of the current transfer
    output logic half_done,
    output logic lead_edge,
    output logic trail_edge,
    output logic sclk
);

    localparam int                 c_CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sclk;

    // Half-period counter; cleared whenever the controller leaves or re-enters a state
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign half_done  = run && (r_cnt == c_CNT_LAST);
    // A toggle away from the idle level is a leading edge, back to it a trailing edge
    assign lead_edge  = half_done && edge_en && (r_sclk == cpol);
    assign trail_edge = half_done && edge_en && (r_sclk != cpol);

    // SCLK register: preset to the new idle level on acceptance, toggled on edge strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk <= 1'b0;
        end else if (load) begin
            r_sclk <= load_cpol;
        end else if (lead_edge || trail_edge) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign sclk = r_sclk;

endmodule
`default_nettype wire

// File: rtl/spi_master_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_controller
//  Description : Single-word SPI master. Accepts a request over valid/ready,
//                runs SETUP / TRANSFER / HOLD with run-time CPOL/CPHA,
//                shifts MOSI MSB-first, captures MISO and returns the
//                received word with a one-cycle rx_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_controller
    import spi_globals_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 1,
    parameter int CLK_DIV      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic [$clog2(NO_OF_SLAVES):0] tx_cs_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    output logic                          rx_valid,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          busy,
    output logic                          sclk,
    output logic [NO_OF_SLAVES-1:0]       cs_n,
    output logic                          mosi,
    input  logic                          miso
);

    localparam int                  c_SEL_W          = $clog2(NO_OF_SLAVES) + 1;
    localparam int                  c_EDGES          = 2 * DATA_WIDTH;
    localparam int                  c_EDGE_W         = $clog2(c_EDGES + 1);
    // TRANSFER spans c_EDGES half-periods; the first toggle happens on entry,
    // so the last half-period only waits and the one before it holds the final trailing edge.
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST      = c_EDGE_W'(c_EDGES - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST_TRAIL = c_EDGE_W'(c_EDGES - 2);

    spi_state_e              r_state;
    spi_state_e              w_state_nxt;
    spi_mode_e               r_mode;
    logic [c_EDGE_W-1:0]     r_edge_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_sh;
    logic [DATA_WIDTH-1:0]   r_rx_sh;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_tx_ready;
    logic                    r_busy;
    logic                    r_mosi;
    logic [NO_OF_SLAVES-1:0] r_cs_n;
    logic [NO_OF_SLAVES-1:0] w_cs_dec;

    logic w_accept;
    logic w_done;
    logic w_run;
    logic w_edge_en;
    logic w_last_trail;
    logic w_half_done;
    logic w_lead;
    logic w_trail;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (w_run),
        .edge_en    (w_edge_en),
        .load       (w_accept),
        .load_cpol  (cpol),
        .cpol       (mode_cpol(r_mode)),
        .half_done  (w_half_done),
        .lead_edge  (w_lead),
        .trail_edge (w_trail),
        .sclk       (sclk)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_run        = (r_state != ST_IDLE);
        w_edge_en    = 1'b0;
        w_last_trail = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_edge_en = 1'b1;
                if (w_half_done) begin
                    w_state_nxt = ST_TRANSFER;
                end
            end
            ST_TRANSFER: begin
                w_edge_en    = (r_edge_cnt != c_EDGE_LAST);
                w_last_trail = (r_edge_cnt == c_EDGE_LAST_TRAIL);
                if (w_half_done && (r_edge_cnt == c_EDGE_LAST)) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_half_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Chip-select decode of the incoming index; out-of-range selects nothing
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (tx_cs_sel == c_SEL_W'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    // Half-period index within TRANSFER, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != r_state)) begin
            r_edge_cnt <= '0;
        end else if ((r_state == ST_TRANSFER) && w_half_done) begin
            r_edge_cnt <= r_edge_cnt + c_EDGE_W'(1);
        end
    end

    // Handshake and status flags track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Request mode and chip selects are captured at acceptance and held for the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= SPI_MODE0;
            r_cs_n <= '1;
        end else if (w_accept) begin
            r_mode <= spi_mode_e'({cpol, cpha});
            r_cs_n <= w_cs_dec;
        end else if (w_done) begin
            r_cs_n <= '1;
        end
    end

    // MOSI drive and MISO capture on the edges selected by CPHA
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_mosi  <= 1'b0;
        end else if (w_accept) begin
            r_rx_sh <= '0;
            if (!cpha) begin
                r_mosi  <= tx_data[DATA_WIDTH-1];
                r_tx_sh <= {tx_data[DATA_WIDTH-2:0], 1'b0};
            end else begin
                r_tx_sh <= tx_data;
            end
        end else if (!mode_cpha(r_mode)) begin
            if (w_lead) begin
                r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], miso};
            end
            if (w_trail && !w_last_trail) begin
                r_mosi  <= r_tx_sh[DATA_WIDTH-1];
                r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            if (w_lead) begin
                r_mosi  <= r_tx_sh[DATA_WIDTH-1];
                r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_trail) begin
                r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], miso};
            end
        end
    end

    // Completed word is published with a single-cycle valid and then held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= w_done;
            if (w_done) begin
                r_rx_data <= r_rx_sh;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign cs_n     = r_cs_n;
    assign mosi     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_controller
//  Description : Self-checking bench for spi_master_controller with a
//                behavioural SPI slave, table vectors, random transfers and
//                hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_controller;

    localparam int DW  = 8;
    localparam int NS  = 4;
    localparam int CD  = 2;
    localparam int LAT = (2 * DW + 2) * CD + 1;   // accept cycle to rx_valid cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [2:0]    tx_cs_sel;
    logic          cpol;
    logic          cpha;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          sclk;
    logic [NS-1:0] cs_n;
    logic          mosi;
    logic          miso;

    int total = 0;
    int bad   = 0;

    // Slave model state
    logic          loop_en = 1'b0;
    logic          s_miso  = 1'b0;
    logic [DW-1:0] s_reply = '0;
    bit            s_cpol  = 1'b0;
    bit            s_cpha  = 1'b0;
    bit            s_active = 1'b0;
    logic          s_prev  = 1'b0;
    int            s_idx   = 0;
    logic [DW-1:0] s_cap   = '0;
    bit            s_lead;

    typedef struct {
        logic [7:0] d;
        logic [2:0] sel;
        bit         pol;
        bit         pha;
        bit         lp;
        logic [7:0] reply;
        logic [7:0] exp_rx;
        bit         scr;
    } vec_t;

    vec_t vecs[7];

    assign miso = loop_en ? mosi : s_miso;

    always #5 clk = ~clk;

    spi_master_controller #(
        .DATA_WIDTH   (DW),
        .NO_OF_SLAVES (NS),
        .CLK_DIV      (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_cs_sel (tx_cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural SPI slave: shifts its reply MSB-first and records MOSI on the
    // sampling edge of the requested mode. Active while the master reports busy.
    always @(negedge clk) begin
        if (!busy) begin
            s_active = 1'b0;
        end else if (!s_active) begin
            s_active = 1'b1;
            s_prev   = sclk;
            s_idx    = DW - 1;
            s_cap    = '0;
            if (!s_cpha) s_miso = s_reply[s_idx];
        end else if (sclk !== s_prev) begin
            s_lead = (s_prev == s_cpol);
            s_prev = sclk;
            if (s_lead != s_cpha) begin
                s_cap = {s_cap[DW-2:0], mosi};
            end else if (!s_cpha) begin
                if (s_idx > 0) begin
                    s_idx  = s_idx - 1;
                    s_miso = s_reply[s_idx];
                end
            end else begin
                if (s_idx >= 0) s_miso = s_reply[s_idx];
                s_idx = s_idx - 1;
            end
        end
    end

    // One complete transfer with protocol and timing checks
    task automatic run_xfer(input logic [7:0] d, input logic [2:0] sel, input bit pol,
                            input bit pha, input bit lp, input logic [7:0] reply,
                            input logic [7:0] exp_rx, input bit scr, input string tag);
        int         n;
        int         cs_low;
        int         toggles;
        bit         got;
        logic       prev_sclk;
        logic [3:0] exp_cs;
        logic [7:0] held;
        exp_cs  = (sel < 3'(NS)) ? ~(4'b0001 << sel) : 4'hF;
        s_reply = reply;
        s_cpol  = pol;
        s_cpha  = pha;
        loop_en = lp;
        @(negedge clk);
        tx_data = d; tx_cs_sel = sel; cpol = pol; cpha = pha; tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 32'(tx_ready), 32'd1);
        cs_low = 0; toggles = 0; got = 1'b0; n = 0; prev_sclk = 1'b0; held = '0;
        while (!got && n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                tx_valid = 1'b0;
                chk({tag, " setup sclk"}, 32'(sclk), 32'(pol));
                if (!pha) chk({tag, " setup mosi"}, 32'(mosi), 32'(d[7]));
                chk({tag, " cs_n"}, 32'(cs_n), 32'(exp_cs));
                chk({tag, " busy"}, 32'(busy), 32'd1);
            end else if (sclk !== prev_sclk) begin
                toggles++;
            end
            prev_sclk = sclk;
            if (cs_n != 4'hF) cs_low++;
            if (rx_valid) begin
                got  = 1'b1;
                held = rx_data;
                chk({tag, " latency"}, 32'(n), 32'(LAT));
                chk({tag, " rx_data"}, 32'(rx_data), 32'(exp_rx));
                chk({tag, " idle sclk"}, 32'(sclk), 32'(pol));
                chk({tag, " cs release"}, 32'(cs_n), 32'hF);
                chk({tag, " ready at rx"}, 32'(tx_ready), 32'd1);
            end
            if (scr && !got) begin
                tx_data   = 8'($urandom);
                cpol      = 1'($urandom);
                cpha      = 1'($urandom);
                tx_cs_sel = 3'($urandom);
            end
        end
        chk({tag, " rx seen"}, 32'(got), 32'd1);
        chk({tag, " cs low cycles"}, 32'(cs_low), (sel < 3'(NS)) ? 32'(LAT - 1) : 32'd0);
        chk({tag, " sclk toggles"}, 32'(toggles), 32'(2 * DW));
        chk({tag, " mosi word"}, 32'(s_cap), 32'(d));
        @(negedge clk);
        chk({tag, " rx pulse"}, 32'(rx_valid), 32'd0);
        chk({tag, " rx hold"}, 32'(rx_data), 32'(held));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         n;
        int         seen;
        logic [7:0] d;
        logic [7:0] r;
        logic [2:0] sel;
        int         m;
        bit         lp;

        vecs[0] = '{8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vecs[1] = '{8'h81, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h81, 1'b0};
        vecs[2] = '{8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h81, 1'b0};
        vecs[3] = '{8'h81, 3'd3, 1'b1, 1'b1, 1'b1, 8'h00, 8'h81, 1'b0};
        vecs[4] = '{8'h5A, 3'd2, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3, 1'b0};
        vecs[5] = '{8'h96, 3'd5, 1'b1, 1'b0, 1'b0, 8'h69, 8'h69, 1'b0};
        vecs[6] = '{8'h3C, 3'd1, 1'b0, 1'b1, 1'b0, 8'hE7, 8'hE7, 1'b1};

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_ready", 32'(tx_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset sclk", 32'(sclk), 32'd0);
        chk("reset cs_n", 32'(cs_n), 32'hF);
        chk("reset mosi", 32'(mosi), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].d, vecs[i].sel, vecs[i].pol, vecs[i].pha, vecs[i].lp,
                     vecs[i].reply, vecs[i].exp_rx, vecs[i].scr, $sformatf("vec%0d", i));
        end

        // Random transfers: received word is the slave reply, or the sent word in loopback
        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom);
            r   = 8'($urandom);
            sel = 3'($urandom_range(0, 7));
            m   = int'($urandom_range(0, 3));
            lp  = 1'($urandom_range(0, 1));
            run_xfer(d, sel, m[1], m[0], lp, r, lp ? d : r, (k % 3) == 0,
                     $sformatf("rand%0d", k));
        end

        // Back-to-back: second request accepted in the rx_valid cycle of the first
        loop_en = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0;
        @(negedge clk);
        tx_data = 8'h00; tx_cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_data = 8'hFF;
        n = 1;
        while (!rx_valid && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first latency", 32'(n), 32'(LAT));
        chk("b2b first rx_data", 32'(rx_data), 32'h00);
        chk("b2b ready at rx", 32'(tx_ready), 32'd1);
        chk("b2b cs gap", 32'(cs_n), 32'hF);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b second busy", 32'(busy), 32'd1);
        chk("b2b second cs", 32'(cs_n), 32'hE);
        n = 1;
        while (!rx_valid && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b second latency", 32'(n), 32'(LAT));
        chk("b2b second rx_data", 32'(rx_data), 32'hFF);

        // Reset in the 10th TRANSFER cycle discards the transfer
        @(negedge clk);
        s_cpol = 1'b1; s_cpha = 1'b1;
        tx_data = 8'hC3; tx_cs_sel = 3'd1; cpol = 1'b1; cpha = 1'b1; tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst sclk", 32'(sclk), 32'd0);
        chk("mid rst cs_n", 32'(cs_n), 32'hF);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst rx_valid", 32'(rx_valid), 32'd0);
        chk("mid rst tx_ready", 32'(tx_ready), 32'd0);
        chk("mid rst mosi", 32'(mosi), 32'd0);
        chk("mid rst rx_data", 32'(rx_data), 32'd0);
        seen = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (rx_valid) seen++;
        end
        chk("mid rst no rx_valid", 32'(seen), 32'd0);
        run_xfer(8'h6D, 3'd3, 1'b0, 1'b1, 1'b0, 8'hB2, 8'hB2, 1'b0, "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
